// File: rtl/cim_pkg.sv
// ---------------------------------------------------------------------------
// cim_pkg
//   Shared geometry and types for the CIM layer input dispatch.
//   A vector is MACRO_NUM*ROWS_PER_MACRO activations.
//   It arrives as BEATS beats of BEAT_LANES lanes each.
//   The vector leaves as MACRO_NUM slices of ROWS_PER_MACRO rows.
// ---------------------------------------------------------------------------
package cim_pkg;

   localparam int MACRO_NUM      = 4;
   localparam int ROWS_PER_MACRO = 64;
   localparam int ACT_W          = 4;
   localparam int BEAT_LANES     = 32;

   localparam int VEC_LANES  = MACRO_NUM * ROWS_PER_MACRO;
   localparam int BEATS      = VEC_LANES / BEAT_LANES;
   localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   // nbeats ranges over 1..BEATS, so it needs one more code than beat_cnt
   localparam int NBEATS_W   = $clog2(BEATS + 1);

   typedef logic [ACT_W-1:0]      act_t;
   typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;
   typedef logic [NBEATS_W-1:0]   nbeats_t;

   typedef act_t [BEAT_LANES-1:0]                     beat_t;
   typedef act_t [MACRO_NUM-1:0][ROWS_PER_MACRO-1:0]  vec_t;

   typedef enum logic {
      BANK_0 = 1'b0,
      BANK_1 = 1'b1
   } bank_t;

   localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(BEATS - 1);

   function automatic bank_t other_bank(input bank_t b);
      return (b == BANK_0) ? BANK_1 : BANK_0;
   endfunction

endpackage

// File: rtl/macro_input_dispatch_if.sv
// ---------------------------------------------------------------------------
// macro_input_dispatch_if
//   Bundles the beat stream into the dispatcher.
//   Also bundles the vector stream out to the macros and the length-error flag.
//   The slave modport is the dispatcher's view.
//   The master modport is the view of the producer/consumer environment.
//   Signals:
//     s_valid/s_ready/s_data/s_last : input beat handshake
//     m_valid/m_ready/m_data        : full vector handshake, split per macro
//     err_len                       : sticky s_last / beat-count mismatch
// ---------------------------------------------------------------------------
interface macro_input_dispatch_if;
   import cim_pkg::*;

   logic  s_valid;
   logic  s_ready;
   beat_t s_data;
   logic  s_last;
   logic  m_valid;
   logic  m_ready;
   vec_t  m_data;
   logic  err_len;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, err_len
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, err_len
   );

endinterface

// File: rtl/macro_input_dispatch_bank.sv
// ---------------------------------------------------------------------------
// dispatch_bank
//   One vector buffer of BEATS x BEAT_LANES activations.
//   It has a beat-indexed write port and records how many beats the stored
//   vector holds (nbeats).
//   The read port presents the whole vector in macro/row order. Lanes that
//   belong to beats >= nbeats read as zero, so a short vector never exposes
//   lanes left over from an older, longer one.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     wr_en         : store wr_data at beat wr_idx
//     wr_idx        : beat slot being written
//     wr_data       : one beat of BEAT_LANES lanes
//     close         : latch close_nbeats as the valid length of this vector
//     close_nbeats  : beat count of the vector being closed (1..BEATS)
//     rd_data       : masked full vector, [macro][row]
// ---------------------------------------------------------------------------
module dispatch_bank
   import cim_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      wr_en,
   input  beat_cnt_t wr_idx,
   input  beat_t     wr_data,
   input  logic      close,
   input  nbeats_t   close_nbeats,
   output vec_t      rd_data
);

   beat_t   mem_q [BEATS];
   beat_t   mem_d [BEATS];
   nbeats_t nbeats_q;
   nbeats_t nbeats_d;

   always_comb begin
      // NOTE: every variable gets a default before any condition; otherwise the unassigned paths infer latches.
      mem_d    = mem_q;
      nbeats_d = nbeats_q;
      if (wr_en) begin
         mem_d[wr_idx] = wr_data;
      end
      if (close) begin
         nbeats_d = close_nbeats;
      end
   end

   // NOTE: the storage array has no reset; it is never read unmasked, because nbeats bounds which beats reach the output.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // NOTE: state is only ever updated with non-blocking assignments, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         nbeats_q <= '0;
      end else begin
         nbeats_q <= nbeats_d;
      end
   end

   // Global lane g = m*ROWS_PER_MACRO + r lives at beat g/BEAT_LANES,
   // lane g%BEAT_LANES of the stored vector.
   always_comb begin
      rd_data = '0;
      for (int m = 0; m < MACRO_NUM; m++) begin
         for (int r = 0; r < ROWS_PER_MACRO; r++) begin
            if (nbeats_t'((m * ROWS_PER_MACRO + r) / BEAT_LANES) < nbeats_q) begin
               rd_data[m][r] = mem_q[(m * ROWS_PER_MACRO + r) / BEAT_LANES]
                                    [(m * ROWS_PER_MACRO + r) % BEAT_LANES];
            end
         end
      end
   end

endmodule

// File: rtl/macro_input_dispatch.sv
// ---------------------------------------------------------------------------
// macro_input_dispatch
//   Front end of the CIM layer datapath.
//   Assembles BEATS serial activation beats into one full input vector.
//   The vector is presented split across MACRO_NUM macros of ROWS_PER_MACRO
//   lanes each.
//   There are two banks: one fills while the other drains.
//   Ports:
//     clk : clock, rising edge
//     rst : synchronous active-high reset
//     bus : slave side of macro_input_dispatch_if
//           (s_* beat input, m_* vector output, err_len)
//   Write side:
//     beat_cnt / wr_bank track where the next beat lands.
//     A vector closes on s_last, or on its BEATS-th beat.
//     A missing s_last on that final beat raises err_len, which stays set
//     until rst.
//   Read side:
//     rd_bank points at the oldest full bank.
//     Since fills alternate banks, "wr_bank full" means both banks are full.
// ---------------------------------------------------------------------------
module macro_input_dispatch
   import cim_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   macro_input_dispatch_if.slave bus
);

   // write-side state
   beat_cnt_t  beat_cnt_q, beat_cnt_d;
   bank_t      wr_bank_q,  wr_bank_d;
   // read-side state
   bank_t      rd_bank_q,  rd_bank_d;
   logic [1:0] full_q,     full_d;
   logic       err_len_q,  err_len_d;

   // per-cycle decisions
   logic       s_ready;
   logic       accept;
   logic       at_last_slot;
   logic       close;
   logic       drain;
   logic       m_valid;

   // bank interface
   logic [1:0] bank_wr_en;
   logic [1:0] bank_close;
   nbeats_t    close_nbeats;
   vec_t       bank_rd [2];
   vec_t       m_data;

   always_comb begin
      // s_ready depends only on registered state: a drain at this edge frees
      // the bank for the next cycle, never combinationally from m_ready.
      s_ready      = !full_q[wr_bank_q];
      accept       = bus.s_valid && s_ready;
      at_last_slot = (beat_cnt_q == LAST_BEAT);
      close        = accept && (bus.s_last || at_last_slot);
      m_valid      = full_q[rd_bank_q];
      drain        = m_valid && bus.m_ready;
      close_nbeats = nbeats_t'(beat_cnt_q) + nbeats_t'(1);

      beat_cnt_d = beat_cnt_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      full_d     = full_q;
      err_len_d  = err_len_q;
      bank_wr_en = '0;
      bank_close = '0;

      if (accept) begin
         bank_wr_en[wr_bank_q] = 1'b1;
         if (close) begin
            bank_close[wr_bank_q] = 1'b1;
            full_d[wr_bank_q]     = 1'b1;
            beat_cnt_d            = '0;
            wr_bank_d             = other_bank(wr_bank_q);
         end else begin
            beat_cnt_d = beat_cnt_q + beat_cnt_t'(1);
         end
         if (at_last_slot && !bus.s_last) begin
            err_len_d = 1'b1;
         end
      end

      // The closing bank is never full, so it can't also be rd_bank with full
      // set. The close and drain updates above and below therefore touch
      // different bits of full.
      if (drain) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = other_bank(rd_bank_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q <= '0;
         wr_bank_q  <= BANK_0;
         rd_bank_q  <= BANK_0;
         full_q     <= '0;
         err_len_q  <= 1'b0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         err_len_q  <= err_len_d;
      end
   end

   dispatch_bank u_bank0 (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (bank_wr_en[0]),
      .wr_idx       (beat_cnt_q),
      .wr_data      (bus.s_data),
      .close        (bank_close[0]),
      .close_nbeats (close_nbeats),
      .rd_data      (bank_rd[0])
   );

   dispatch_bank u_bank1 (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (bank_wr_en[1]),
      .wr_idx       (beat_cnt_q),
      .wr_data      (bus.s_data),
      .close        (bank_close[1]),
      .close_nbeats (close_nbeats),
      .rd_data      (bank_rd[1])
   );

   // m_data is forced to zero whenever no vector is presented.
   always_comb begin
      m_data = '0;
      if (m_valid) begin
         m_data = (rd_bank_q == BANK_0) ? bank_rd[0] : bank_rd[1];
      end
   end

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid;
   assign bus.m_data  = m_data;
   assign bus.err_len = err_len_q;

endmodule

// File: tb/tb_macro_input_dispatch.sv
// ---------------------------------------------------------------------------
// tb_macro_input_dispatch
//   Reference model: a queue of complete expected vectors plus the vector
//   currently being assembled.
//   Beats are placed by global lane number. Vectors close on s_last or on the
//   BEATS-th beat.
//   The model predicts the handshakes:
//     - it accepts while fewer than two vectors are queued
//     - m_valid is high while the queue is non-empty
// ---------------------------------------------------------------------------
module tb_macro_input_dispatch;
   import cim_pkg::*;

   localparam int CW = ROWS_PER_MACRO * ACT_W;

   logic clk = 1'b0;
   logic rst = 1'b1;

   macro_input_dispatch_if bus ();

   macro_input_dispatch dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;

   vec_t exp_q[$];
   vec_t cur;
   int   cnt;
   bit   err_m;

   task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, compare current outputs against the model,
   // advance the model by what happens at the coming edge, then step past it.
   task automatic cycle(input bit r, input bit v, input beat_t d, input bit lst,
                        input bit mr, output bit acc);
      vec_t e;
      bit   drain;
      int   g;
      rst         = r;
      bus.s_valid = v;
      bus.s_data  = d;
      bus.s_last  = lst;
      bus.m_ready = mr;
      check("s_ready", CW'(bus.s_ready), CW'(exp_q.size() < 2));
      check("m_valid", CW'(bus.m_valid), CW'(exp_q.size() > 0));
      check("err_len", CW'(bus.err_len), CW'(err_m));
      e = (exp_q.size() > 0) ? exp_q[0] : '0;
      for (int m = 0; m < MACRO_NUM; m++) begin
         check($sformatf("m_data[%0d]", m), bus.m_data[m], e[m]);
      end
      acc = 1'b0;
      if (r) begin
         exp_q.delete();
         cur   = '0;
         cnt   = 0;
         err_m = 1'b0;
      end else begin
         drain = (exp_q.size() > 0) && mr;
         acc   = v && (exp_q.size() < 2);
         if (drain) void'(exp_q.pop_front());
         if (acc) begin
            for (int li = 0; li < BEAT_LANES; li++) begin
               g = cnt * BEAT_LANES + li;
               cur[g / ROWS_PER_MACRO][g % ROWS_PER_MACRO] = d[li];
            end
            if (cnt == BEATS - 1 && !lst) err_m = 1'b1;
            cnt++;
            if (lst || cnt == BEATS) begin
               exp_q.push_back(cur);
               cur = '0;
               cnt = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Hold a beat until accepted; n returns the cycles spent (bounded).
   task automatic offer(input beat_t d, input bit lst, input bit mr, output int n);
      bit acc;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
         cycle(1'b0, 1'b1, d, lst, mr, acc);
         n++;
      end
      if (!acc) check("offer_timeout", CW'(0), CW'(1));
   endtask

   task automatic idle(input int n, input bit mr);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, mr, acc);
   endtask

   function automatic beat_t ramp_beat(input int b);
      beat_t d;
      for (int l = 0; l < BEAT_LANES; l++) d[l] = act_t'((b * BEAT_LANES + l) % 16);
      return d;
   endfunction

   function automatic beat_t fill_beat(input act_t v);
      beat_t d;
      for (int l = 0; l < BEAT_LANES; l++) d[l] = v;
      return d;
   endfunction

   function automatic beat_t rand_beat();
      beat_t d;
      for (int l = 0; l < BEAT_LANES; l++) d[l] = act_t'($urandom_range(0, 15));
      return d;
   endfunction

   initial begin
      int    n;
      int    sum;
      bit    acc;
      vec_t  all3;
      beat_t b17;

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      cur   = '0;
      cnt   = 0;
      err_m = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // 1: full ramp vector, one-cycle latency, spot lanes
      for (int b = 0; b < BEATS; b++) offer(ramp_beat(b), b == BEATS - 1, 1'b1, n);
      check("t1_latency_m_valid", CW'(bus.m_valid), CW'(1));
      check("t1_lane64",  CW'(bus.m_data[1][0]),  CW'(0));
      check("t1_lane255", CW'(bus.m_data[3][63]), CW'(15));
      idle(3, 1'b1);

      // 2: stall consumer, fill both banks, 17th beat waits for a drain
      for (int b = 0; b < 2 * BEATS; b++) offer(rand_beat(), (b % BEATS) == BEATS - 1, 1'b0, n);
      b17 = rand_beat();
      for (int i = 0; i < 3; i++) begin
         check("t2_stalled_s_ready", CW'(bus.s_ready), CW'(0));
         cycle(1'b0, 1'b1, b17, 1'b0, 1'b0, acc);
      end
      offer(b17, 1'b0, 1'b1, n);
      check("t2_beat17_cycles", CW'(n), CW'(2));
      for (int b = 1; b < BEATS; b++) offer(rand_beat(), b == BEATS - 1, 1'b1, n);
      idle(4, 1'b1);

      // 3: short vector of 3 beats
      for (int b = 0; b < 3; b++) offer(fill_beat(4'hF), b == 2, 1'b1, n);
      check("t3_lane95", CW'(bus.m_data[1][31]), CW'(15));
      check("t3_lane96", CW'(bus.m_data[1][32]), CW'(0));
      check("t3_err_len", CW'(bus.err_len), CW'(0));
      idle(3, 1'b1);

      // 4: no s_last at all -> err_len sticks
      for (int b = 0; b < BEATS; b++) offer(rand_beat(), 1'b0, 1'b1, n);
      check("t4_m_valid", CW'(bus.m_valid), CW'(1));
      idle(5, 1'b1);
      check("t4_err_sticky", CW'(bus.err_len), CW'(1));

      // 5: reset mid-vector, then a clean all-3 vector
      for (int b = 0; b < 4; b++) offer(rand_beat(), 1'b0, 1'b0, n);
      cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
      check("t5_rst_s_ready", CW'(bus.s_ready), CW'(1));
      check("t5_rst_m_valid", CW'(bus.m_valid), CW'(0));
      for (int b = 0; b < BEATS; b++) offer(fill_beat(4'h3), b == BEATS - 1, 1'b0, n);
      all3 = '0;
      for (int m = 0; m < MACRO_NUM; m++)
         for (int r = 0; r < ROWS_PER_MACRO; r++) all3[m][r] = 4'h3;
      for (int m = 0; m < MACRO_NUM; m++) check("t5_all3", bus.m_data[m], all3[m]);
      idle(3, 1'b1);

      // 6: continuous stream, no bubbles
      sum = 0;
      for (int v = 0; v < 5; v++)
         for (int b = 0; b < BEATS; b++) begin
            offer(rand_beat(), b == BEATS - 1, 1'b1, n);
            sum += n;
         end
      check("t6_cycles", CW'(sum), CW'(5 * BEATS));
      idle(3, 1'b1);

      // random traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), rand_beat(),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < 7), acc);
      end
      idle(6, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
